fetch_stage: RTL

- Instruction-fetch stage sitting directly upstream of the control unit.
- Owns the program counter, drives the asynchronous-read instruction memory, and registers the fetched word into the IF/ID instruction register.
- The opcode field of that register feeds the control unit's 5-bit opcode input.
- Consumes the control unit's PC-select decision (branch taken) plus a target address, and squashes wrong-path fetches.

---
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch stage's bus signals: control-unit redirect inputs,
// instruction-memory address/data, and the IF/ID register outputs.
//   stall          : freeze the fetch stage
//   branch_taken   : redirect request from the control unit PC-select
//   branch_target  : redirect address
//   imem_addr      : instruction memory address (combinational from PC)
//   imem_rdata     : instruction memory read data (combinational read)
//   instr_out      : registered instruction word (IF/ID register)
//   opcode_out     : top five bits of instr_out, to the control unit
//   pc_out         : address instr_out was fetched from
//   valid_out      : instr_out holds a real instruction, not a bubble
//   fetch_count    : number of valid instructions loaded since reset
// master = fetch stage side, slave = memory / control-unit side.
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
);
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_out;
    logic [4:0]         opcode_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               valid_out;
    logic [15:0]        fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, instr_out, opcode_out, pc_out, valid_out, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, instr_out, opcode_out, pc_out, valid_out, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the program counter, addresses an
// asynchronous-read instruction memory and registers the fetched word into
// the IF/ID instruction register. Taken branches from the control unit
// redirect the PC and squash wrong-path fetches with NOP bubbles.
// Ports:
//   clk  : system clock, rising-edge active
//   rst  : synchronous active-high reset
//   bus  : fetch_stage_if.master (redirect inputs, imem bus, IF/ID outputs)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                 ADDR_W         = 10,
    parameter int                 INSTR_W        = 32,
    parameter int                 BRANCH_PENALTY = 1,
    parameter logic [INSTR_W-1:0] NOP_WORD       = 32'hB800_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [1:0] ST_BOOT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    // First value of the flush counter after an accepted branch; the bubble
    // written on the accepting edge counts as the first penalty cycle.
    localparam logic [3:0] FLUSH_INIT = 4'(BRANCH_PENALTY - 1);

    logic [1:0]         state_q,  state_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic [ADDR_W-1:0]  pc_q,     pc_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q,  instr_d;
    logic               valid_q,  valid_d;
    logic [15:0]        count_q,  count_d;

    // Next-state logic: boot, sequential fetch, branch redirect and flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        count_d  = count_q;

        if (!bus.stall) begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A redirect is only honoured behind a real instruction.
                    if (valid_q && bus.branch_taken) begin
                        pc_d    = bus.branch_target;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        if (BRANCH_PENALTY > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        instr_d  = bus.imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + ADDR_W'(1);
                        count_d  = count_q + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover through BOOT with a bubble.
                    state_d = ST_BOOT;
                    cnt_d   = 4'd0;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            cnt_q    <= 4'd0;
            pc_q     <= '0;
            pc_out_q <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.opcode_out  = instr_q[INSTR_W-1 -: 5];
    assign bus.pc_out      = pc_out_q;
    assign bus.valid_out   = valid_q;
    assign bus.fetch_count = count_q;

endmodule
